hack_ctrl_seq: RTL and testbench
================================

// Module: hack_ctrl_seq
// PURPOSE
//  Multicycle HACK control/sequencer that sits directly upstream and downstream of the ALU.
//  - Fetches instructions over a req/ack ROM port and decodes A/C instructions.
//  - Holds the A, D and PC registers; drives the ALU operands and control bits.
//  - Consumes the ALU result for A/D/M writeback and jump resolution.
//  - Talks to data RAM through a separate req/ack port.
// PARAMETERS
//  WIDTH     16  datapath / instruction width
//  ADDR_W    15  instruction and data address width; addresses use A[ADDR_W-1:0]
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  imem_req    out  1       instruction fetch request
//  imem_addr   out  ADDR_W  fetch address (= PC)
//  imem_ack    in   1       fetch done; imem_data valid this cycle
//  imem_data   in   WIDTH   instruction word
//  dmem_rd     out  1       data read request
//  dmem_wr     out  1       data write request
//  dmem_addr   out  ADDR_W  data address (A captured at EXEC)
//  dmem_wdata  out  WIDTH   write data
//  dmem_ack    in   1       data access done; dmem_rdata valid this cycle on reads
//  dmem_rdata  in   WIDTH   read data
//  alu_x       out  WIDTH   = D
//  alu_y       out  WIDTH   = M latch if IR[12] else A
//  alu_zx,alu_nx,alu_zy,alu_ny,alu_f,alu_no  out 1 each  = IR[11:6], in that order
//  alu_out     in   WIDTH   combinational ALU result
//  pc_out      out  ADDR_W  current PC
// BEHAVIOUR
//  Reset (async, immediate): state=FETCH; PC=RESET_PC; A=D=IR=M latch=0; all req/rd/wr low.
//  Reset mid-transaction: the transfer is abandoned; an ack arriving in the first cycle after reset is ignored.
//  FSM states: FETCH, MEMRD, EXEC, MEMWR.
//  FETCH:
//   - imem_req=1, held until imem_ack; on ack IR<=imem_data.
//   - Next state is MEMRD if imem_data[15]&imem_data[12], else EXEC.
//  MEMRD:
//   - dmem_rd=1, dmem_addr=A, held until dmem_ack; on ack M latch<=dmem_rdata, go to EXEC.
//  EXEC, A-instruction (IR[15]=0): A<=IR (MSB 0); PC<=PC+1; go to FETCH.
//  EXEC, C-instruction:
//   - Dest bits: IR[5] A<=alu_out; IR[4] D<=alu_out.
//   - Flags derived locally: zr=(alu_out==0), ng=alu_out[WIDTH-1].
//   - Jump: jmp=(IR[2]&ng)|(IR[1]&zr)|(IR[0]&~ng&~zr).
//   - PC<=jmp ? A_old[ADDR_W-1:0] : PC+1.
//   - If IR[3]: latch wdata=alu_out and addr=A_old, go to MEMWR; else go to FETCH.
//  MEMWR: dmem_wr=1 with the latched addr/data, held until dmem_ack, then go to FETCH.
//  Old-A rule: writeback to A and M in one instruction uses pre-update A for the M address and the jump target.
//  Latency (zero-wait acks): A-instr 2 cycles; C 2; C+read 3; C+write 3; C+read+write 4.
//  Stalls: req/addr/wdata stay stable until ack; no request is withdrawn except by reset.
//  Exclusivity: dmem_rd and dmem_wr are never high together.
//  PC wraps 2^ADDR_W-1 -> 0 with no flag.
//  IR[14:13] ignored.
//  ALU control outputs are valid from the cycle after the IR load through EXEC.
// CONFIGURATION
//  HACK_RETIRE_CNT_EN defined:
//   - Adds output port retired[31:0], reset 0.
//   - +1 on every EXEC->FETCH transition or MEMWR ack; wraps at 2^32.
//  HACK_RETIRE_CNT_EN undefined: the port and the counter logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset, ROM 0:@5 (0x0005), zero-wait acks -> A=5, PC=1 after 2 cycles; imem_req high in cycle 0.
//  2. @7; D=A (0xEC10); D=D+A (0xE090) -> D=14 after 6 cycles; no dmem_rd/dmem_wr seen.
//  3. @100; M=1 (0xEFC8) -> single dmem_wr, addr=100, wdata=1.
//     - Hold dmem_ack low 3 cycles: wr/addr/wdata stay stable; PC=2 after ack.
//  4. @3; AM=M+1 (0xFDE8), RAM[3]=9:
//     - dmem_rd addr=3, then dmem_wr addr=3 data=10.
//     - A=10 afterwards; 4-cycle instruction.
//  5. D=-1 via 0xEE90; @20; D;JLT (0xE304) -> PC=20.
//     - D=0: D;JEQ taken, D;JGT not taken (PC+1).
//  6. Assert rst during a MEMRD stall -> immediate FETCH, PC=0, dmem_rd low.
//     - A stale ack the next cycle has no effect.
//     - With HACK_RETIRE_CNT_EN: retired=0.

Source files
------------

// File: rtl/hack_ctrl_seq_if.sv
// Connections between the HACK sequencer and its instruction ROM, data RAM and ALU.
// The master modport is the sequencer side; the slave modport is the ROM/RAM/ALU side.
interface hack_ctrl_seq_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WIDTH-1:0]  imem_data;

  logic              dmem_rd;
  logic              dmem_wr;
  logic [ADDR_W-1:0] dmem_addr;
  logic [WIDTH-1:0]  dmem_wdata;
  logic              dmem_ack;
  logic [WIDTH-1:0]  dmem_rdata;

  logic [WIDTH-1:0]  alu_x;
  logic [WIDTH-1:0]  alu_y;
  logic              alu_zx;
  logic              alu_nx;
  logic              alu_zy;
  logic              alu_ny;
  logic              alu_f;
  logic              alu_no;
  logic [WIDTH-1:0]  alu_out;

  logic [ADDR_W-1:0] pc_out;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  alu_out,
    output pc_out
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output alu_out,
    input  pc_out
  );
endinterface

// File: rtl/hack_ctrl_seq.sv
// Multicycle HACK control/sequencer: fetch, optional M read, execute, optional M write.
// Define HACK_RETIRE_CNT_EN to add the 32-bit retired-instruction counter port.
module hack_ctrl_seq #(
  parameter int          WIDTH    = 16,
  parameter int          ADDR_W   = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef HACK_RETIRE_CNT_EN
  output logic [31:0] retired,
`endif
  hack_ctrl_seq_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MEMRD = 2'd1,
    EXEC  = 2'd2,
    MEMWR = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [WIDTH-1:0]  ir_q, ir_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              ack_mask_q;

  logic imem_ok;
  logic dmem_ok;
  logic zr;
  logic ng;
  logic jmp;

  // Acks landing in the first cycle after reset belong to an abandoned transfer.
  assign imem_ok = bus.imem_ack & ~ack_mask_q;
  assign dmem_ok = bus.dmem_ack & ~ack_mask_q;

  assign zr  = (bus.alu_out == '0);
  assign ng  = bus.alu_out[WIDTH-1];
  assign jmp = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= ADDR_W'(RESET_PC);
      a_q        <= '0;
      d_q        <= '0;
      ir_q       <= '0;
      m_q        <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ack_mask_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      d_q        <= d_d;
      ir_q       <= ir_d;
      m_q        <= m_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ack_mask_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    m_d     = m_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ok) begin
          ir_d    = bus.imem_data;
          state_d = (bus.imem_data[WIDTH-1] & bus.imem_data[12]) ? MEMRD : EXEC;
        end
      end
      MEMRD: begin
        if (dmem_ok) begin
          m_d     = bus.dmem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        pc_d = pc_q + ADDR_W'(1);
        if (!ir_q[WIDTH-1]) begin
          a_d     = {1'b0, ir_q[WIDTH-2:0]};
          state_d = FETCH;
        end else begin
          if (ir_q[5]) a_d = bus.alu_out;
          if (ir_q[4]) d_d = bus.alu_out;
          // Jump target and M address both use A as it was before this instruction.
          if (jmp) pc_d = a_q[ADDR_W-1:0];
          if (ir_q[3]) begin
            waddr_d = a_q[ADDR_W-1:0];
            wdata_d = bus.alu_out;
            state_d = MEMWR;
          end else begin
            state_d = FETCH;
          end
        end
      end
      MEMWR: begin
        if (dmem_ok) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.imem_req   = (state_q == FETCH) & ~rst;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_rd    = (state_q == MEMRD);
  assign bus.dmem_wr    = (state_q == MEMWR);
  assign bus.dmem_addr  = (state_q == MEMWR) ? waddr_q : a_q[ADDR_W-1:0];
  assign bus.dmem_wdata = wdata_q;
  assign bus.alu_x      = d_q;
  assign bus.alu_y      = ir_q[12] ? m_q : a_q;
  assign bus.alu_zx     = ir_q[11];
  assign bus.alu_nx     = ir_q[10];
  assign bus.alu_zy     = ir_q[9];
  assign bus.alu_ny     = ir_q[8];
  assign bus.alu_f      = ir_q[7];
  assign bus.alu_no     = ir_q[6];
  assign bus.pc_out     = pc_q;

`ifdef HACK_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (((state_q == EXEC) && (state_d == FETCH)) ||
                 ((state_q == MEMWR) && dmem_ok)) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_hack_ctrl_seq.sv
// Bench for hack_ctrl_seq: ROM/RAM/ALU responders, an instruction-level HACK model
// checked every cycle, and directed programs with hand-computed expectations.
module tb_hack_ctrl_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hack_ctrl_seq_if #(.WIDTH(16), .ADDR_W(15)) bus ();

`ifdef HACK_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  hack_ctrl_seq #(.WIDTH(16), .ADDR_W(15), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
`ifdef HACK_RETIRE_CNT_EN
    .retired (retired),
`endif
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  // ---------------- memories and ALU ----------------
  logic [15:0] rom   [0:32767];
  logic [15:0] ram   [0:32767];
  logic [15:0] m_ram [0:32767];
  int   dmem_wait = 0;
  int   dcnt = 0;
  logic force_ack = 1'b0;

  assign bus.imem_ack   = bus.imem_req;
  assign bus.imem_data  = rom[bus.imem_addr];
  assign bus.dmem_ack   = force_ack | ((bus.dmem_rd | bus.dmem_wr) & (dcnt >= dmem_wait));
  assign bus.dmem_rdata = ram[bus.dmem_addr];
  assign bus.alu_out    = hack_alu(bus.alu_x, bus.alu_y,
                                   {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no});

  always @(posedge clk) begin
    if ((bus.dmem_rd | bus.dmem_wr) & ~bus.dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (bus.dmem_wr & bus.dmem_ack) ram[bus.dmem_addr] = bus.dmem_wdata;
  end

  // ---------------- instruction-level model ----------------
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic        exp_rd, exp_wr, rd_done, wr_done;
  logic [14:0] exp_rd_addr, exp_wr_addr;
  logic [15:0] exp_wr_data;
  logic        guard, have_prev;
  int          fetch_cnt, rd_cnt, wr_cnt, waits, total_waits, cyc_since;
  logic [14:0] last_rd_addr, last_wr_addr;
  logic [15:0] last_wr_data;
  logic [15:0] pc_log [0:63];
  logic [15:0] ax_log [0:63];
  logic [15:0] ay_log [0:63];
  int          cyc_log [0:63];

  task automatic iss_step();
    logic [15:0] ir, old_a, y, r;
    logic        take;
    ir     = rom[m_pc];
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (!ir[15]) begin
      m_a  = ir;
      m_pc = m_pc + 15'd1;
    end else begin
      old_a       = m_a;
      y           = ir[12] ? m_ram[old_a[14:0]] : old_a;
      r           = hack_alu(m_d, y, ir[11:6]);
      exp_rd      = ir[12];
      exp_rd_addr = old_a[14:0];
      exp_wr      = ir[3];
      exp_wr_addr = old_a[14:0];
      exp_wr_data = r;
      if (ir[5]) m_a = r;
      if (ir[4]) m_d = r;
      take = (ir[2] && $signed(r) < 0) || (ir[1] && r == 16'h0) || (ir[0] && $signed(r) > 0);
      m_pc = take ? old_a[14:0] : m_pc + 15'd1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_a = '0; m_d = '0; m_pc = '0;
      exp_rd = 1'b0; exp_wr = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
      guard = 1'b1; have_prev = 1'b0;
      fetch_cnt = 0; rd_cnt = 0; wr_cnt = 0; waits = 0; total_waits = 0; cyc_since = 0;
    end else begin
      if (bus.dmem_rd && bus.dmem_wr) chk("rd_wr_exclusive", 32'd1, 32'd0);
      if (bus.dmem_rd) begin
        chk("rd_expected", {31'd0, exp_rd & ~rd_done}, 32'd1);
        chk("rd_addr", {17'd0, bus.dmem_addr}, {17'd0, exp_rd_addr});
        if (bus.dmem_ack) begin
          rd_done = 1'b1; rd_cnt++; last_rd_addr = bus.dmem_addr;
          $display("dmem read  addr=%0d data=%h", bus.dmem_addr, bus.dmem_rdata);
        end else begin
          waits++; total_waits++;
        end
      end
      if (bus.dmem_wr) begin
        chk("wr_expected", {31'd0, exp_wr & ~wr_done}, 32'd1);
        chk("wr_addr", {17'd0, bus.dmem_addr}, {17'd0, exp_wr_addr});
        chk("wr_data", {16'd0, bus.dmem_wdata}, {16'd0, exp_wr_data});
        if (bus.dmem_ack) begin
          wr_done = 1'b1; wr_cnt++;
          last_wr_addr = bus.dmem_addr; last_wr_data = bus.dmem_wdata;
          m_ram[exp_wr_addr] = exp_wr_data;
          $display("dmem write addr=%0d data=%h", bus.dmem_addr, bus.dmem_wdata);
        end else begin
          waits++; total_waits++;
        end
      end
      if (bus.imem_req) chk("fetch_addr", {17'd0, bus.imem_addr}, {17'd0, m_pc});
      if (bus.imem_req && bus.imem_ack && !guard) begin
        if (have_prev) begin
          chk("latency", cyc_since, 2 + (exp_rd ? 1 : 0) + (exp_wr ? 1 : 0) + waits);
          chk("rd_done", {31'd0, rd_done}, {31'd0, exp_rd});
          chk("wr_done", {31'd0, wr_done}, {31'd0, exp_wr});
        end
        chk("pc_out", {17'd0, bus.pc_out}, {17'd0, m_pc});
        chk("alu_x_is_D", {16'd0, bus.alu_x}, {16'd0, m_d});
`ifdef HACK_RETIRE_CNT_EN
        chk("retired", retired, fetch_cnt);
`endif
        if (fetch_cnt < 63) fetch_cnt++;
        pc_log[fetch_cnt]  = {1'b0, bus.pc_out};
        ax_log[fetch_cnt]  = bus.alu_x;
        ay_log[fetch_cnt]  = bus.alu_y;
        cyc_log[fetch_cnt] = cyc_since;
        $display("fetch #%0d pc=%h ir=%h D=%h", fetch_cnt, bus.pc_out, bus.imem_data, bus.alu_x);
        iss_step();
        have_prev = 1'b1; cyc_since = 0; waits = 0; rd_done = 1'b0; wr_done = 1'b0;
      end
      guard = 1'b0;
      cyc_since++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rst_on();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_dmem_rd", {31'd0, bus.dmem_rd}, 32'd0);
    chk("rst_dmem_wr", {31'd0, bus.dmem_wr}, 32'd0);
    chk("rst_pc", {17'd0, bus.pc_out}, 32'd0);
    chk("rst_alu_x", {16'd0, bus.alu_x}, 32'd0);
    chk("rst_alu_y", {16'd0, bus.alu_y}, 32'd0);
`ifdef HACK_RETIRE_CNT_EN
    chk("rst_retired", retired, 32'd0);
`endif
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000; ram[i] = 16'h0000; m_ram[i] = 16'h0000;
    end
  endtask

  task automatic rst_off();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_ram(input int addr, input logic [15:0] val);
    ram[addr] = val;
    m_ram[addr] = val;
  endtask

  task automatic wait_fetches(input int n);
    for (int i = 0; i < 300 && fetch_cnt < n; i++) @(posedge clk);
    chk("fetch_count", fetch_cnt, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: @5 -> A=5, PC=1; imem_req high in the first cycle out of reset
    rst_on();
    rom[0] = 16'h0005; rom[1] = 16'h0005;
    rst_off();
    @(negedge clk);
    chk("t1_cycle0_req", {31'd0, bus.imem_req}, 32'd1);
    wait_fetches(2);
    chk("t1_pc", pc_log[2], 16'd1);
    chk("t1_A", ay_log[2], 16'd5);

    // 2: @7; D=A; D=D+A -> D=14, no data traffic
    rst_on();
    rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'hE090;
    rst_off();
    wait_fetches(4);
    chk("t2_D", ax_log[4], 16'd14);
    chk("t2_latency", cyc_log[4], 32'd2);
    chk("t2_no_dmem", rd_cnt + wr_cnt, 32'd0);

    // 3: @100; M=1 with 3 wait cycles on the write
    rst_on();
    rom[0] = 16'h0064; rom[1] = 16'hEFC8;
    dmem_wait = 3;
    rst_off();
    wait_fetches(3);
    chk("t3_wr_cnt", wr_cnt, 32'd1);
    chk("t3_wr_addr", {17'd0, last_wr_addr}, 32'd100);
    chk("t3_wr_data", {16'd0, last_wr_data}, 32'd1);
    chk("t3_waits", total_waits, 32'd3);
    chk("t3_pc", pc_log[3], 16'd2);
    chk("t3_ram", {16'd0, ram[100]}, 32'd1);

    // 4: @3; AM=M+1 with RAM[3]=9; then D=A
    rst_on();
    rom[0] = 16'h0003; rom[1] = 16'hFDE8; rom[2] = 16'hEC10;
    set_ram(3, 16'd9);
    dmem_wait = 0;
    rst_off();
    wait_fetches(4);
    chk("t4_rd_addr", {17'd0, last_rd_addr}, 32'd3);
    chk("t4_wr_addr", {17'd0, last_wr_addr}, 32'd3);
    chk("t4_wr_data", {16'd0, last_wr_data}, 32'd10);
    chk("t4_M_latch", ay_log[3], 16'd9);
    chk("t4_latency", cyc_log[3], 32'd4);
    chk("t4_A", ax_log[4], 16'd10);

    // 5: D=-1; @20; D;JLT taken. D=0; @30; D;JEQ taken. @40; D;JGT not taken.
    rst_on();
    rom[0]  = 16'hEE90; rom[1]  = 16'h0014; rom[2]  = 16'hE304;
    rom[20] = 16'hEA90; rom[21] = 16'h001E; rom[22] = 16'hE302;
    rom[30] = 16'h0028; rom[31] = 16'hE301;
    rst_off();
    wait_fetches(9);
    chk("t5_D_neg", ax_log[3], 16'hFFFF);
    chk("t5_jlt", pc_log[4], 16'd20);
    chk("t5_jeq", pc_log[7], 16'd30);
    chk("t5_jgt", pc_log[9], 16'd32);

    // 7: PC wraps from 0x7FFF to 0
    rst_on();
    rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0001;
    rst_off();
    wait_fetches(4);
    chk("t7_jmp", pc_log[3], 16'h7FFF);
    chk("t7_wrap", pc_log[4], 16'd0);

    // 6: reset during a stalled M read, stale ack right after release
    rst_on();
    rom[0] = 16'h0005; rom[1] = 16'hFC10;
    set_ram(5, 16'h1234);
    dmem_wait = 20;
    rst_off();
    for (int i = 0; i < 50 && !bus.dmem_rd; i++) @(negedge clk);
    chk("t6_rd_seen", {31'd0, bus.dmem_rd}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rd_low", {31'd0, bus.dmem_rd}, 32'd0);
    chk("t6_pc", {17'd0, bus.pc_out}, 32'd0);
`ifdef HACK_RETIRE_CNT_EN
    chk("t6_retired", retired, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0; force_ack = 1'b1; dmem_wait = 0;
    @(negedge clk);
    chk("t6_fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t6_no_rd", {31'd0, bus.dmem_rd}, 32'd0);
    @(posedge clk);
    #1 force_ack = 1'b0;
    wait_fetches(3);
    chk("t6_pc_after", pc_log[3], 16'd2);
    chk("t6_D", ax_log[3], 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
